// File: rtl/ibf_cfg_loader.sv
// Select-vector loader for the inverse-butterfly mux stage: assembles write beats
// in a shadow register and commits the shadow to the active select vector atomically.
module ibf_cfg_loader #(
    parameter  int N_NUM       = 32,
    parameter  int DATA_WIDTH  = 4096,
    parameter  int WR_WIDTH    = 32,
    localparam int CFG_BIT_NUM = $clog2(N_NUM),
    localparam int MUX_NUM     = DATA_WIDTH / N_NUM,
    localparam int CFG_WIDTH   = CFG_BIT_NUM * MUX_NUM
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_wr_valid,
    output logic                 cfg_wr_ready,
    input  logic [WR_WIDTH-1:0]  cfg_wr_data,
    input  logic                 cfg_wr_last,
    input  logic                 commit_req,
    output logic [CFG_WIDTH-1:0] cfg_out,
    output logic                 cfg_pending,
    output logic                 cfg_applied,
    output logic                 cfg_err
);

    localparam int              BEATS    = (CFG_WIDTH + WR_WIDTH - 1) / WR_WIDTH;
    localparam int              CNT_W    = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t               state_q,   state_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [CFG_WIDTH-1:0] shadow_q,  shadow_d;
    logic [CFG_WIDTH-1:0] cfg_out_q, cfg_out_d;
    logic                 applied_q, applied_d;
    logic                 err_q,     err_d;

    logic                 xfer;
    logic [CNT_W-1:0]     beat_idx;

    // Ready depends on state only, so there is no combinational valid->ready path.
    assign cfg_wr_ready = (state_q != FULL);
    assign cfg_pending  = (state_q == FULL);
    assign cfg_out      = cfg_out_q;
    assign cfg_applied  = applied_q;
    assign cfg_err      = err_q;

    assign xfer     = cfg_wr_valid && cfg_wr_ready;
    assign beat_idx = (state_q == LOAD) ? cnt_q : '0;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        cfg_out_d = cfg_out_q;
        applied_d = 1'b0;
        err_d     = 1'b0;

        // Bits of the final beat that fall above CFG_WIDTH have no shadow bit and drop out.
        if (xfer) begin
            for (int i = 0; i < CFG_WIDTH; i++) begin
                if ((i / WR_WIDTH) == int'(beat_idx)) begin
                    shadow_d[i] = cfg_wr_data[i % WR_WIDTH];
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    cnt_d = CNT_W'(1);
                    if (BEATS == 1) begin
                        if (cfg_wr_last) begin
                            state_d = FULL;
                        end else begin
                            err_d = 1'b1;
                            cnt_d = '0;
                        end
                    end else if (cfg_wr_last) begin
                        err_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end

            LOAD: begin
                if (xfer) begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d = '0;
                        if (cfg_wr_last) begin
                            state_d = FULL;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (cfg_wr_last) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            FULL: begin
                // A commit on the completing beat's cycle is sampled in LOAD and never reaches here.
                if (commit_req) begin
                    cfg_out_d = shadow_q;
                    applied_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shadow_q  <= '0;
            cfg_out_q <= '0;
            applied_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            cfg_out_q <= cfg_out_d;
            applied_q <= applied_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_ibf_cfg_loader.sv
// Self-checking bench for ibf_cfg_loader: a transaction-level model checked every cycle,
// plus directed literal expectations for each scenario.
module tb_ibf_cfg_loader;

    localparam int N_NUM      = 4;
    localparam int DATA_WIDTH = 16;
    localparam int WR_WIDTH   = 4;
    localparam int CFG_WIDTH  = 8;
    localparam int BEATS      = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 cfg_wr_valid;
    logic                 cfg_wr_ready;
    logic [WR_WIDTH-1:0]  cfg_wr_data;
    logic                 cfg_wr_last;
    logic                 commit_req;
    logic [CFG_WIDTH-1:0] cfg_out;
    logic                 cfg_pending;
    logic                 cfg_applied;
    logic                 cfg_err;

    int n_checks = 0;
    int n_fail   = 0;

    ibf_cfg_loader #(
        .N_NUM      (N_NUM),
        .DATA_WIDTH (DATA_WIDTH),
        .WR_WIDTH   (WR_WIDTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_wr_valid (cfg_wr_valid),
        .cfg_wr_ready (cfg_wr_ready),
        .cfg_wr_data  (cfg_wr_data),
        .cfg_wr_last  (cfg_wr_last),
        .commit_req   (commit_req),
        .cfg_out      (cfg_out),
        .cfg_pending  (cfg_pending),
        .cfg_applied  (cfg_applied),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: beats collected since the last boundary, a pending image, the active image.
    logic [WR_WIDTH-1:0]  beats_q[$];
    bit                   m_init    = 1'b0;
    bit                   m_pending = 1'b0;
    logic [CFG_WIDTH-1:0] m_image   = '0;
    logic [CFG_WIDTH-1:0] m_out     = '0;
    bit                   m_applied = 1'b0;
    bit                   m_err     = 1'b0;

    function automatic logic [CFG_WIDTH-1:0] assemble();
        logic [31:0] acc = 0;
        for (int k = 0; k < beats_q.size(); k++) begin
            acc = acc | (32'(beats_q[k]) << (k * WR_WIDTH));
        end
        return acc[CFG_WIDTH-1:0];
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            beats_q.delete();
            m_init    = 1'b1;
            m_pending = 1'b0;
            m_image   = '0;
            m_out     = '0;
            m_applied = 1'b0;
            m_err     = 1'b0;
        end else begin
            m_applied = 1'b0;
            m_err     = 1'b0;
            if (m_pending) begin
                if (commit_req) begin
                    m_out     = m_image;
                    m_pending = 1'b0;
                    m_applied = 1'b1;
                end
            end else if (cfg_wr_valid) begin
                beats_q.push_back(cfg_wr_data);
                if (cfg_wr_last) begin
                    if (beats_q.size() == BEATS) begin
                        m_image   = assemble();
                        m_pending = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                    beats_q.delete();
                end else if (beats_q.size() == BEATS) begin
                    m_err = 1'b1;
                    beats_q.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("cyc_cfg_out", 32'(cfg_out), 32'(m_out));
            check("cyc_ready",   32'(cfg_wr_ready), 32'(!m_pending));
            check("cyc_pending", 32'(cfg_pending), 32'(m_pending));
            check("cyc_applied", 32'(cfg_applied), 32'(m_applied));
            check("cyc_err",     32'(cfg_err), 32'(m_err));
        end
    end

    // Inputs change 1 time unit after a rising edge and are consumed at the following edge.
    task automatic drive(input logic v, input logic [WR_WIDTH-1:0] d, input logic l, input logic c);
        @(posedge clk);
        #1;
        cfg_wr_valid = v;
        cfg_wr_data  = d;
        cfg_wr_last  = l;
        commit_req   = c;
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n        = 1'b0;
        cfg_wr_valid = 1'b1;
        cfg_wr_data  = 4'h5;
        cfg_wr_last  = 1'b0;
        commit_req   = 1'b0;

        // 1. Reset with valid asserted
        repeat (2) @(posedge clk);
        #1;
        check("rst_cfg_out", 32'(cfg_out), 32'h00);
        check("rst_ready",   32'(cfg_wr_ready), 32'h1);
        check("rst_pending", 32'(cfg_pending), 32'h0);
        check("rst_applied", 32'(cfg_applied), 32'h0);
        check("rst_err",     32'(cfg_err), 32'h0);
        rst_n        = 1'b1;
        cfg_wr_valid = 1'b0;

        // 2. Normal load and commit
        drive(1'b1, 4'hB, 1'b0, 1'b0);
        drive(1'b1, 4'h6, 1'b1, 1'b0);
        idle();
        check("load_pending", 32'(cfg_pending), 32'h1);
        check("load_ready",   32'(cfg_wr_ready), 32'h0);
        check("load_cfg_out", 32'(cfg_out), 32'h00);
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        idle();
        check("commit_cfg_out", 32'(cfg_out), 32'h6B);
        check("commit_applied", 32'(cfg_applied), 32'h1);
        check("commit_ready",   32'(cfg_wr_ready), 32'h1);
        idle();
        check("applied_one_cycle", 32'(cfg_applied), 32'h0);

        // 3. Short vector
        drive(1'b1, 4'h3, 1'b1, 1'b0);
        idle();
        check("short_err",     32'(cfg_err), 32'h1);
        check("short_cfg_out", 32'(cfg_out), 32'h6B);
        check("short_pending", 32'(cfg_pending), 32'h0);
        check("short_ready",   32'(cfg_wr_ready), 32'h1);
        idle();
        check("err_one_cycle", 32'(cfg_err), 32'h0);

        // 4. Missing last, then a valid load
        drive(1'b1, 4'h1, 1'b0, 1'b0);
        drive(1'b1, 4'h2, 1'b0, 1'b0);
        idle();
        check("nolast_err",     32'(cfg_err), 32'h1);
        check("nolast_cfg_out", 32'(cfg_out), 32'h6B);
        drive(1'b1, 4'hF, 1'b0, 1'b0);
        drive(1'b1, 4'h0, 1'b1, 1'b0);
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        idle();
        check("reload_cfg_out", 32'(cfg_out), 32'h0F);
        check("reload_applied", 32'(cfg_applied), 32'h1);

        // 5. Commit timing
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        idle();
        check("idle_commit_cfg_out", 32'(cfg_out), 32'h0F);
        check("idle_commit_applied", 32'(cfg_applied), 32'h0);
        drive(1'b1, 4'hA, 1'b0, 1'b1);
        drive(1'b1, 4'hC, 1'b1, 1'b1);
        idle();
        check("coinc_cfg_out", 32'(cfg_out), 32'h0F);
        check("coinc_pending", 32'(cfg_pending), 32'h1);
        check("coinc_applied", 32'(cfg_applied), 32'h0);
        drive(1'b1, 4'h7, 1'b1, 1'b0);
        drive(1'b1, 4'h7, 1'b0, 1'b0);
        drive(1'b1, 4'h7, 1'b0, 1'b1);
        idle();
        check("full_hold_cfg_out", 32'(cfg_out), 32'hCA);
        check("full_hold_applied", 32'(cfg_applied), 32'h1);
        check("full_hold_err",     32'(cfg_err), 32'h0);

        // 6. Reset mid-load
        drive(1'b1, 4'h9, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n        = 1'b0;
        cfg_wr_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_cfg_out", 32'(cfg_out), 32'h00);
        check("midrst_pending", 32'(cfg_pending), 32'h0);
        check("midrst_ready",   32'(cfg_wr_ready), 32'h1);
        drive(1'b1, 4'h5, 1'b0, 1'b0);
        drive(1'b1, 4'hE, 1'b1, 1'b0);
        idle();
        check("midrst_load_err",     32'(cfg_err), 32'h0);
        check("midrst_load_pending", 32'(cfg_pending), 32'h1);
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        idle();
        check("midrst_commit_cfg_out", 32'(cfg_out), 32'hE5);

        repeat (3) idle();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
